// File: rtl/registro_solicitudes.sv
// registro_solicitudes: synchronizes and debounces raw push-buttons and latches
// one pending-request bit per button until the elevator algorithm serves it.
//   solicitudes  -> algorithm solicitudes_inicial input
//   atendidos    <- algorithm served/clear mask
// Build option: define SOLICITUDES_CANCEL_EN to make a fresh press on an
// already-pending button cancel that request instead of being ignored.
module registro_solicitudes #(
  parameter int N_BOTONES       = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BOTONES-1:0] botones,
  input  logic [N_BOTONES-1:0] atendidos,
  output logic [N_BOTONES-1:0] solicitudes,
  output logic                 nueva_solicitud,
  output logic [N_BOTONES-1:0] estable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_BOTONES-1:0] sync_s1;
  logic [N_BOTONES-1:0] sync_s2;
  logic [CNT_W-1:0]     cnt [N_BOTONES];
  logic [N_BOTONES-1:0] flip;
  logic [N_BOTONES-1:0] press_q;
  logic [N_BOTONES-1:0] sol_next;

  // Flip condition: synchronized level has differed for the full debounce window
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < N_BOTONES; i++) begin
      flip[i] = (sync_s2[i] != estable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Two-flop synchronizer for the asynchronous button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= botones;
      sync_s2 <= sync_s1;
    end
  end

  // Per-button debounce counter and stable level; any return to the stable level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estable <= '0;
      for (int unsigned i = 0; i < N_BOTONES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BOTONES; i++) begin
        if (sync_s2[i] == estable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          estable[i] <= sync_s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Press event (rising stable level) is registered, so the latch acts one edge after estable flips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
    end else begin
      press_q <= flip & sync_s2;
    end
  end

  // Next request state: clear from atendidos beats a press on the same bit
  always_comb begin
    sol_next = solicitudes;
    for (int unsigned i = 0; i < N_BOTONES; i++) begin
      if (atendidos[i]) begin
        sol_next[i] = 1'b0;
      end else if (press_q[i]) begin
`ifdef SOLICITUDES_CANCEL_EN
        sol_next[i] = ~solicitudes[i];
`else
        sol_next[i] = 1'b1;
`endif
      end
    end
  end

  // Request latch plus a single pulse whenever any request bit rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      solicitudes     <= '0;
      nueva_solicitud <= 1'b0;
    end else begin
      solicitudes     <= sol_next;
      nueva_solicitud <= |(sol_next & ~solicitudes);
    end
  end

endmodule

// File: tb/tb_registro_solicitudes.sv
// Testbench for registro_solicitudes (DEBOUNCE_CYCLES=4).
module tb_registro_solicitudes;

  localparam int N = 10;
  localparam int D = 4;
`ifdef SOLICITUDES_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] botones;
  logic [N-1:0] atendidos;
  logic [N-1:0] solicitudes;
  logic         nueva_solicitud;
  logic [N-1:0] estable;

  int checks = 0;
  int errors = 0;

  registro_solicitudes #(
    .N_BOTONES(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botones(botones),
    .atendidos(atendidos),
    .solicitudes(solicitudes),
    .nueva_solicitud(nueva_solicitud),
    .estable(estable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a button's stable level flips once the last D synchronized
  // samples all disagree with it; the request latch reacts one edge later.
  logic [N-1:0] m_s1, m_s2, m_est, m_pq, m_sol;
  logic         m_nueva;
  logic [N-1:0] hist [D];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_est = '0; m_pq = '0; m_sol = '0; m_nueva = 1'b0;
    for (int j = 0; j < D; j++) hist[j] = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] b, input logic [N-1:0] a);
    logic [N-1:0] fl;
    logic [N-1:0] sn;
    for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = m_s2;
    fl = '1;
    for (int j = 0; j < D; j++) fl = fl & (hist[j] ^ m_est);
    if (CANCEL) sn = (m_sol ^ m_pq) & ~a;
    else        sn = (m_sol | m_pq) & ~a;
    m_nueva = |(sn & ~m_sol);
    m_sol   = sn;
    m_pq    = fl & m_s2;
    m_est   = m_est ^ fl;
    m_s2    = m_s1;
    m_s1    = b;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_solicitudes", solicitudes, m_sol);
    check("model_nueva", {9'd0, nueva_solicitud}, {9'd0, m_nueva});
    check("model_estable", estable, m_est);
  endtask

  // One clock: drive inputs, advance DUT and model, compare on the falling edge
  task automatic step(input logic [N-1:0] b, input logic [N-1:0] a);
    botones   = b;
    atendidos = a;
    @(posedge clk);
    model_edge(b, a);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [N-1:0] bot;
    logic [N-1:0] at;
    int           n;
    logic [N-1:0] exp_sol;
    logic         exp_nueva;
    logic [N-1:0] exp_est;
  } seg_t;

  seg_t tbl [$];
  logic [N-1:0] repress_sol;
  logic [N-1:0] rb, ra;

  initial begin
    rst_n = 1'b0;
    botones = '0;
    atendidos = '0;
    model_reset();

    // Button held through reset: all outputs zero, then a full-latency press
    botones = 10'h3FF;
    repeat (3) @(negedge clk);
    check("reset_solicitudes", solicitudes, '0);
    check("reset_nueva", {9'd0, nueva_solicitud}, '0);
    check("reset_estable", estable, '0);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(10'h3FF, '0);
      if (c == 6) check("hold_reset_e6_sol", solicitudes, '0);
      if (c == 7) begin
        check("hold_reset_e7_sol", solicitudes, 10'h3FF);
        check("hold_reset_e7_nueva", {9'd0, nueva_solicitud}, 10'h001);
      end
      if (c == 8) check("hold_reset_e8_nueva", {9'd0, nueva_solicitud}, '0);
    end
    step(10'h3FF, 10'h3FF);
    repeat (8) step('0, '0);

    // Table-driven directed segments, checked at the end of each segment
    repress_sol = CANCEL ? 10'h000 : 10'h004;
    tbl.push_back('{bot:10'h008, at:10'h000, n:3,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h000, at:10'h000, n:10, exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h201, at:10'h000, n:7,  exp_sol:10'h201, exp_nueva:1'b1, exp_est:10'h201});
    tbl.push_back('{bot:10'h201, at:10'h000, n:1,  exp_sol:10'h201, exp_nueva:1'b0, exp_est:10'h201});
    tbl.push_back('{bot:10'h201, at:10'h201, n:1,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h201});
    tbl.push_back('{bot:10'h000, at:10'h000, n:8,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h008, at:10'h000, n:7,  exp_sol:10'h008, exp_nueva:1'b1, exp_est:10'h008});
    tbl.push_back('{bot:10'h008, at:10'h008, n:1,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h008});
    tbl.push_back('{bot:10'h008, at:10'h000, n:10, exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h008});
    tbl.push_back('{bot:10'h000, at:10'h000, n:6,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h008, at:10'h000, n:7,  exp_sol:10'h008, exp_nueva:1'b1, exp_est:10'h008});
    tbl.push_back('{bot:10'h008, at:10'h008, n:1,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h008});
    tbl.push_back('{bot:10'h000, at:10'h000, n:8,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h020, at:10'h000, n:6,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h020});
    tbl.push_back('{bot:10'h020, at:10'h020, n:1,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h020});
    tbl.push_back('{bot:10'h020, at:10'h000, n:3,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h020});
    tbl.push_back('{bot:10'h000, at:10'h000, n:8,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h004, at:10'h000, n:7,  exp_sol:10'h004, exp_nueva:1'b1, exp_est:10'h004});
    tbl.push_back('{bot:10'h000, at:10'h000, n:8,  exp_sol:10'h004, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h004, at:10'h000, n:7,  exp_sol:repress_sol, exp_nueva:1'b0, exp_est:10'h004});
    tbl.push_back('{bot:10'h000, at:10'h000, n:8,  exp_sol:repress_sol, exp_nueva:1'b0, exp_est:10'h000});
    tbl.push_back('{bot:10'h000, at:10'h3FF, n:1,  exp_sol:10'h000, exp_nueva:1'b0, exp_est:10'h000});

    for (int k = 0; k < tbl.size(); k++) begin
      for (int c = 0; c < tbl[k].n; c++) step(tbl[k].bot, tbl[k].at);
      check($sformatf("seg%0d_sol", k), solicitudes, tbl[k].exp_sol);
      check($sformatf("seg%0d_nueva", k), {9'd0, nueva_solicitud}, {9'd0, tbl[k].exp_nueva});
      check($sformatf("seg%0d_est", k), estable, tbl[k].exp_est);
    end

    // Reset mid-debounce discards progress: the press needs the full latency again
    repeat (4) step(10'h002, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_est", estable, '0);
    check("async_reset_sol", solicitudes, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(10'h002, '0);
      if (c == 5) check("post_reset_e5_est", estable, '0);
      if (c == 6) check("post_reset_e6_sol", solicitudes, '0);
      if (c == 7) check("post_reset_e7_sol", solicitudes, 10'h002);
    end
    step(10'h002, 10'h002);
    repeat (8) step('0, '0);

    // Randomized activity against the reference model
    rb = '0;
    for (int c = 0; c < 2000; c++) begin
      ra = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
        if ($urandom_range(0, 15) == 0) ra[i] = 1'b1;
      end
      step(rb, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
